valid_delay_line: RTL and testbench
===================================

VALID_DELAY_LINE -- requirements
Module: valid_delay_line

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits, >=1.
REQ-002 SHALL have parameter DELAY, default 2: pipeline depth in cycles, >=1.
REQ-003 SHALL have parameter HOLD, default 1: 1 = out retains last delivered value; 0 = out shows raw final-stage data.
REQ-004 SHALL have port clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port in_valid  input  1  input sample present this cycle.
REQ-007 SHALL have port in  input  WIDTH  input sample.
REQ-008 SHALL have port stall  input  1  freeze all stages; input ignored.
REQ-009 SHALL have port flush  input  1  invalidate all in-flight samples.
REQ-010 SHALL have port out_valid  output  1  delayed sample present.
REQ-011 SHALL have port out  output  WIDTH  delayed sample data.
REQ-012 SHALL have port busy  output  1  any stage holds a valid sample.
REQ-013 SHALL have port count  output  $clog2(DELAY+1)  number of valid samples in flight; present only per REQ-030.

Function
REQ-014 SHALL hold DELAY stages, each a valid bit v[i] plus data d[i], i = 0..DELAY-1.
REQ-015 SHALL, when stall=0 and flush=0, load v[0]<=in_valid, d[0]<=in, and v[i]<=v[i-1], d[i]<=d[i-1] for i>=1 on each rising clk edge.
REQ-016 SHALL, when stall=1 and flush=0, hold all v[i] and d[i] unchanged; in and in_valid are dropped.
REQ-017 SHALL, when flush=1, clear all v[i] to 0 on the next edge, regardless of stall; d[i] untouched; in dropped.
REQ-018 SHALL drive out_valid = v[DELAY-1] combinationally; latency in->out_valid is exactly DELAY cycles with no stalls, plus one cycle per stalled cycle.
REQ-019 SHALL, with HOLD=0, drive out = d[DELAY-1] combinationally.
REQ-020 SHALL, with HOLD=1, drive out = d[DELAY-1] when v[DELAY-1]=1, else the held register last_out.
REQ-021 SHALL update last_out <= d[DELAY-1] on every edge where v[DELAY-1]=1 and stall=0; flush does not modify last_out.
REQ-022 SHALL drive busy = OR of all v[i].
REQ-023 SHALL maintain count: flush -> 0; stall -> unchanged; otherwise count + in_valid - v[DELAY-1]; never exceeds DELAY, never wraps.
REQ-024 SHALL, for DELAY=1, behave as a single valid-tagged register with identical rules.

Reset
REQ-025 SHALL on reset clear all v[i], d[i], last_out and count to 0 on the next edge; reset overrides stall and flush.
REQ-026 SHALL present out_valid=0, busy=0, out=0, count=0 the cycle after reset is sampled high.
REQ-027 SHALL discard any in-flight samples when reset asserts mid-operation; no sample emerges after reset.

Configuration
REQ-028 SHALL compile the occupancy counter under macro VALID_DELAY_LINE_COUNT_EN.
REQ-029 SHALL, without the macro, omit count port and counter logic; all other behaviour identical.
REQ-030 SHALL, with the macro defined, include count port and logic per REQ-023.

Verification
REQ-031 SHALL cover: DELAY=3, WIDTH=8, in=0x11/0x22/0x33 valid cycles 0-2 -> out_valid=1 with out=0x11/0x22/0x33 at cycles 3-5, busy high cycles 1-5.
REQ-032 SHALL cover: DELAY=3, 0xA5 valid cycle 0, stall=1 cycles 1-2 -> out_valid=1, out=0xA5 at cycle 5; in_valid during stall not delivered.
REQ-033 SHALL cover: DELAY=3, valids cycles 0-1, flush=1 with stall=1 at cycle 2 -> out_valid never rises, busy=0 and count=0 at cycle 3.
REQ-034 SHALL cover: HOLD=1, 0x5A delivered then in_valid=0 -> out stays 0x5A with out_valid=0; HOLD=0 -> out tracks d[DELAY-1] (0 after bubbles).
REQ-035 SHALL cover: macro defined, DELAY=4, continuous in_valid 6 cycles -> count 1,2,3,4,4,4 then decrements to 0; reset mid-stream -> count=0, out=0 next cycle.
REQ-036 SHALL cover: DELAY=1, in=0xFF valid with stall=0 -> out_valid=1, out=0xFF next cycle.

Source files
------------

// File: rtl/valid_delay_line_if.sv
// Handshake bundle for valid_delay_line: sample input, pipeline controls and delayed output.
interface valid_delay_line_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in;
    logic             stall;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic             busy;

    modport master (
        output in_valid, in, stall, flush,
        input  out_valid, out, busy
    );

    modport slave (
        input  in_valid, in, stall, flush,
        output out_valid, out, busy
    );
endinterface

// File: rtl/valid_delay_line.sv
// Fixed-latency valid-tagged delay line with stall, flush and optional output hold.
// Define VALID_DELAY_LINE_COUNT_EN to add the in-flight occupancy counter and its count port.
module valid_delay_line #(
    parameter int WIDTH = 32,
    parameter int DELAY = 2,
    parameter int HOLD  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    valid_delay_line_if.slave          bus
`ifdef VALID_DELAY_LINE_COUNT_EN
    ,
    output logic [$clog2(DELAY+1)-1:0] count
`endif
);

    logic [DELAY-1:0] v_r;
    logic [WIDTH-1:0] d_r [DELAY];
    logic [WIDTH-1:0] last_out_r;

    // Stage registers: flush only kills valids, stall freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_r <= '0;
            for (int i = 0; i < DELAY; i++) begin
                d_r[i] <= '0;
            end
        end else if (bus.flush) begin
            v_r <= '0;
        end else if (!bus.stall) begin
            v_r[0] <= bus.in_valid;
            d_r[0] <= bus.in;
            for (int i = 1; i < DELAY; i++) begin
                v_r[i] <= v_r[i-1];
                d_r[i] <= d_r[i-1];
            end
        end
    end

    // Capture each sample as it leaves the final stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_out_r <= '0;
        end else if (v_r[DELAY-1] && !bus.stall) begin
            last_out_r <= d_r[DELAY-1];
        end
    end

    assign bus.out_valid = v_r[DELAY-1];
    assign bus.busy      = |v_r;

    generate
        if (HOLD != 0) begin : g_hold
            // Show the live final stage when valid, otherwise the last delivered sample.
            always_comb begin
                if (v_r[DELAY-1]) begin
                    bus.out = d_r[DELAY-1];
                end else begin
                    bus.out = last_out_r;
                end
            end
        end else begin : g_raw
            assign bus.out = d_r[DELAY-1];
        end
    endgenerate

`ifdef VALID_DELAY_LINE_COUNT_EN
    localparam int CW = $clog2(DELAY+1);
    logic [CW-1:0] count_r;

    // Occupancy: an entering sample and a leaving sample can cancel in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            count_r <= '0;
        end else if (!bus.stall) begin
            count_r <= count_r + CW'(bus.in_valid) - CW'(v_r[DELAY-1]);
        end
    end

    assign count = count_r;
`endif

endmodule

// File: tb/tb_valid_delay_line.sv
// Self-checking bench: four configurations share one stimulus stream and a queue-based reference model.
module tb_valid_delay_line;

    localparam int NDUT = 4;

    logic       clk;
    logic       reset;
    logic       t_valid;
    logic [7:0] t_data;
    logic       t_stall;
    logic       t_flush;

    int total = 0;
    int bad   = 0;

    // Per-DUT configuration: delay depth and hold mode.
    int dly [NDUT] = '{3, 3, 1, 4};
    bit hld [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b1};

    // Model: each queue lists in-flight tokens {valid,data}, newest at front, oldest at back.
    logic [8:0] mq    [NDUT][$];
    logic [7:0] mlast [NDUT];

    valid_delay_line_if #(.WIDTH(8)) if0 ();
    valid_delay_line_if #(.WIDTH(8)) if1 ();
    valid_delay_line_if #(.WIDTH(8)) if2 ();
    valid_delay_line_if #(.WIDTH(8)) if3 ();

    assign if0.in_valid = t_valid; assign if0.in = t_data; assign if0.stall = t_stall; assign if0.flush = t_flush;
    assign if1.in_valid = t_valid; assign if1.in = t_data; assign if1.stall = t_stall; assign if1.flush = t_flush;
    assign if2.in_valid = t_valid; assign if2.in = t_data; assign if2.stall = t_stall; assign if2.flush = t_flush;
    assign if3.in_valid = t_valid; assign if3.in = t_data; assign if3.stall = t_stall; assign if3.flush = t_flush;

`ifdef VALID_DELAY_LINE_COUNT_EN
    logic [1:0] cnt0;
    logic [1:0] cnt1;
    logic [0:0] cnt2;
    logic [2:0] cnt3;
`endif

    valid_delay_line #(.WIDTH(8), .DELAY(3), .HOLD(1)) u0 (
        .clk(clk), .reset(reset), .bus(if0.slave)
`ifdef VALID_DELAY_LINE_COUNT_EN
        , .count(cnt0)
`endif
    );
    valid_delay_line #(.WIDTH(8), .DELAY(3), .HOLD(0)) u1 (
        .clk(clk), .reset(reset), .bus(if1.slave)
`ifdef VALID_DELAY_LINE_COUNT_EN
        , .count(cnt1)
`endif
    );
    valid_delay_line #(.WIDTH(8), .DELAY(1), .HOLD(1)) u2 (
        .clk(clk), .reset(reset), .bus(if2.slave)
`ifdef VALID_DELAY_LINE_COUNT_EN
        , .count(cnt2)
`endif
    );
    valid_delay_line #(.WIDTH(8), .DELAY(4), .HOLD(1)) u3 (
        .clk(clk), .reset(reset), .bus(if3.slave)
`ifdef VALID_DELAY_LINE_COUNT_EN
        , .count(cnt3)
`endif
    );

    logic [NDUT-1:0] obs_v;
    logic [NDUT-1:0] obs_b;
    logic [7:0]      obs_d [NDUT];
    logic [31:0]     obs_c [NDUT];

    assign obs_v = {if3.out_valid, if2.out_valid, if1.out_valid, if0.out_valid};
    assign obs_b = {if3.busy, if2.busy, if1.busy, if0.busy};
    assign obs_d[0] = if0.out;
    assign obs_d[1] = if1.out;
    assign obs_d[2] = if2.out;
    assign obs_d[3] = if3.out;
`ifdef VALID_DELAY_LINE_COUNT_EN
    assign obs_c[0] = 32'(cnt0);
    assign obs_c[1] = 32'(cnt1);
    assign obs_c[2] = 32'(cnt2);
    assign obs_c[3] = 32'(cnt3);
`else
    assign obs_c[0] = 32'd0;
    assign obs_c[1] = 32'd0;
    assign obs_c[2] = 32'd0;
    assign obs_c[3] = 32'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Advance the reference model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        logic [8:0] tok;
        for (int k = 0; k < NDUT; k++) begin
            if (reset) begin
                mq[k].delete();
                for (int j = 0; j < dly[k]; j++) mq[k].push_back(9'h000);
                mlast[k] = 8'h00;
            end else begin
                tok = mq[k][mq[k].size()-1];
                if (tok[8] && !t_stall) mlast[k] = tok[7:0];
                if (t_flush) begin
                    for (int j = 0; j < mq[k].size(); j++) begin
                        tok = mq[k][j];
                        tok[8] = 1'b0;
                        mq[k][j] = tok;
                    end
                end else if (!t_stall) begin
                    void'(mq[k].pop_back());
                    mq[k].push_front({t_valid, t_data});
                end
            end
        end
    endtask

    task automatic check_all();
        logic [8:0] oldest;
        int         nv;
        logic [7:0] exp_d;
        for (int k = 0; k < NDUT; k++) begin
            oldest = mq[k][mq[k].size()-1];
            nv = 0;
            foreach (mq[k][j]) nv += int'(mq[k][j][8]);
            exp_d = (hld[k] && !oldest[8]) ? mlast[k] : oldest[7:0];
            chk("out_valid", k, 32'(obs_v[k]), 32'(oldest[8]));
            chk("out", k, 32'(obs_d[k]), 32'(exp_d));
            chk("busy", k, 32'(obs_b[k]), 32'(nv != 0));
`ifdef VALID_DELAY_LINE_COUNT_EN
            chk("count", k, obs_c[k], 32'(nv));
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic s, input logic f);
        t_valid = v; t_data = d; t_stall = s; t_flush = f;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        reset = 1'b0;
    endtask

    int exp_cnt [10] = '{1, 2, 3, 4, 4, 4, 3, 2, 1, 0};

    initial begin
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk); model_step();
        #1;
        check_all();
        do_reset();
        chk("rst_out", 0, 32'(if0.out), 32'h00);
        chk("rst_busy", 3, 32'(if3.busy), 32'h0);

        // Three back-to-back samples through DELAY=3.
        drive(1'b1, 8'h11, 1'b0, 1'b0); step();
        chk("seq_busy_c1", 0, 32'(if0.busy), 32'h1);
        chk("d1_out_c1", 2, 32'(if2.out), 32'h11);
        drive(1'b1, 8'h22, 1'b0, 1'b0); step();
        drive(1'b1, 8'h33, 1'b0, 1'b0); step();
        chk("seq_c3_v", 0, 32'(if0.out_valid), 32'h1);
        chk("seq_c3_d", 0, 32'(if0.out), 32'h11);
        drive(1'b0, 8'h00, 1'b0, 1'b0); step();
        chk("seq_c4_d", 0, 32'(if0.out), 32'h22);
        step();
        chk("seq_c5_d", 0, 32'(if0.out), 32'h33);
        chk("seq_c5_busy", 0, 32'(if0.busy), 32'h1);
        step();
        chk("hold_v", 0, 32'(if0.out_valid), 32'h0);
        chk("hold_d", 0, 32'(if0.out), 32'h33);
        chk("raw_d", 1, 32'(if1.out), 32'h00);

        // Stall delays delivery; sample offered during stall is dropped.
        do_reset();
        drive(1'b1, 8'hA5, 1'b0, 1'b0); step();
        drive(1'b1, 8'hEE, 1'b1, 1'b0); step(); step();
        drive(1'b0, 8'h00, 1'b0, 1'b0); step();
        chk("stall_c4_v", 0, 32'(if0.out_valid), 32'h0);
        step();
        chk("stall_c5_v", 0, 32'(if0.out_valid), 32'h1);
        chk("stall_c5_d", 0, 32'(if0.out), 32'hA5);
        step();
        chk("stall_drop", 0, 32'(if0.out_valid), 32'h0);

        // Flush with stall kills everything in flight.
        do_reset();
        drive(1'b1, 8'h01, 1'b0, 1'b0); step();
        drive(1'b1, 8'h02, 1'b0, 1'b0); step();
        drive(1'b0, 8'h00, 1'b1, 1'b1); step();
        chk("flush_busy", 0, 32'(if0.busy), 32'h0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step();

        // DELAY=1 single register.
        drive(1'b1, 8'hFF, 1'b0, 1'b0); step();
        chk("d1_v", 2, 32'(if2.out_valid), 32'h1);
        chk("d1_d", 2, 32'(if2.out), 32'hFF);

        // Occupancy fill/drain on DELAY=4, then reset mid-stream.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(i < 6, 8'(8'h40 + i), 1'b0, 1'b0);
            step();
`ifdef VALID_DELAY_LINE_COUNT_EN
            chk("cnt_seq", 3, obs_c[3], 32'(exp_cnt[i]));
`endif
        end
        drive(1'b1, 8'h77, 1'b0, 1'b0); step(); step(); step(); step();
        reset = 1'b1; step(); reset = 1'b0;
        chk("midrst_out", 3, 32'(if3.out), 32'h00);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 99) < 60, 8'($urandom),
                  $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 5);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
